// File: rtl/ropuf_pkg.sv
// RO-PUF key collector shared types and defaults.
// Imported by the collector, its vote sub-module and the bundle interface.
package ropuf_pkg;
  localparam int KEY_W        = 128;
  localparam int SEL_W        = $clog2(KEY_W);
  localparam int CNT_W        = 8;
  localparam int VOTE_W       = 3;
  localparam int VOTE_TH      = 4;
  localparam int EVAL_START_D = 245;
  localparam int EVAL_END_D   = 250;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MEASURE,
    S_SHIFT,
    S_DONE
  } state_t;
endpackage

// File: rtl/ropuf_key_collector_if.sv
// Bundle between the key collector, the RO comparator and the AES key path.
// master = collector side, slave = environment side.
interface ropuf_key_collector_if;
  import ropuf_pkg::*;

  logic             start;
  logic             cmp_out;
  logic [CNT_W-1:0] count;
  logic             ro_en;
  logic             ro_clr;
  logic [SEL_W-1:0] pair_sel;
  logic             busy;
  logic [KEY_W-1:0] key;
  logic             key_valid;

  modport master (
    input  start, cmp_out,
    output count, ro_en, ro_clr, pair_sel,
    output busy, key, key_valid
  );

  modport slave (
    output start, cmp_out,
    input  count, ro_en, ro_clr, pair_sel,
    input  busy, key, key_valid
  );
endinterface

// File: rtl/ropuf_window_vote.sv
// Majority vote of the comparator bit over the evaluation window.
// Ties resolve to 0 because the threshold sits above half the window.
module ropuf_window_vote
  import ropuf_pkg::*;
#(
  parameter int EVAL_START = EVAL_START_D,
  parameter int EVAL_END   = EVAL_END_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_meas,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_cmp,
  output logic             o_bit
);

  logic [VOTE_W-1:0] r_votes;
  logic              w_win;

  assign w_win = i_meas
              && (i_count >= CNT_W'(EVAL_START))
              && (i_count <= CNT_W'(EVAL_END));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_votes <= '0;
    end else if (i_clr) begin
      r_votes <= '0;
    end else if (w_win && i_cmp) begin
      r_votes <= r_votes + 1'b1;
    end
  end

  assign o_bit = (r_votes >= VOTE_W'(VOTE_TH));

endmodule

// File: rtl/ropuf_key_collector.sv
// Sequences RO pair measurements and shifts voted bits into the key.
// Every output is registered from the next-state decode.
module ropuf_key_collector
  import ropuf_pkg::*;
#(
  parameter int EVAL_START = EVAL_START_D,
  parameter int EVAL_END   = EVAL_END_D
) (
  input  logic clk,
  input  logic rst,
  ropuf_key_collector_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count;
  logic             r_ro_en;
  logic             w_ro_en;
  logic             r_ro_clr;
  logic             w_ro_clr;
  logic             r_busy;
  logic             w_busy;
  logic             r_kv;
  logic             w_kv;
  logic [SEL_W-1:0] r_pair;
  logic [SEL_W-1:0] w_pair;
  logic [KEY_W-1:0] r_key;
  logic [KEY_W-1:0] w_key;
  logic             w_bit;
  logic             w_go;
  logic             w_last;
  logic             w_top;

  assign w_go   = bus.start
               && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last = (r_pair == SEL_W'(KEY_W - 1));
  assign w_top  = &r_count;

  ropuf_window_vote #(
    .EVAL_START (EVAL_START),
    .EVAL_END   (EVAL_END)
  ) u_vote (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == S_CLEAR),
    .i_meas  (r_state == S_MEASURE),
    .i_count (r_count),
    .i_cmp   (bus.cmp_out),
    .o_bit   (w_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_ro_en  <= 1'b0;
      r_ro_clr <= 1'b0;
      r_busy   <= 1'b0;
      r_kv     <= 1'b0;
      r_pair   <= '0;
      r_key    <= '0;
    end else begin
      r_state  <= w_next;
      r_count  <= w_count;
      r_ro_en  <= w_ro_en;
      r_ro_clr <= w_ro_clr;
      r_busy   <= w_busy;
      r_kv     <= w_kv;
      r_pair   <= w_pair;
      r_key    <= w_key;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_DONE:    if (bus.start) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_MEASURE;
      S_MEASURE: if (w_top) w_next = S_SHIFT;
      S_SHIFT:   w_next = w_last ? S_DONE : S_CLEAR;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_count = '0;
    if ((r_state == S_MEASURE) && (w_next == S_MEASURE))
      w_count = r_count + 1'b1;
    w_ro_en  = (w_next == S_MEASURE)
            && (w_count < CNT_W'(EVAL_START));
    w_ro_clr = (w_next == S_CLEAR);
    w_busy   = (w_next == S_CLEAR)
            || (w_next == S_MEASURE)
            || (w_next == S_SHIFT);
    w_kv     = (w_next == S_DONE);
    w_pair   = r_pair;
    w_key    = r_key;
    if (w_go) begin
      w_pair = '0;
      w_key  = '0;
    end else if (r_state == S_SHIFT) begin
      // pair 0 enters at the LSB and ends up at the MSB
      w_key = {r_key[KEY_W-2:0], w_bit};
      if (!w_last) w_pair = r_pair + 1'b1;
    end
  end

  assign bus.count     = r_count;
  assign bus.ro_en     = r_ro_en;
  assign bus.ro_clr    = r_ro_clr;
  assign bus.pair_sel  = r_pair;
  assign bus.busy      = r_busy;
  assign bus.key       = r_key;
  assign bus.key_valid = r_kv;

endmodule

// File: tb/tb_ropuf_key_collector.sv
// Directed bench for ropuf_key_collector with a behavioural comparator.
// cmp_out is a pure function of pair_sel, count and the active pattern.
module tb_ropuf_key_collector;
  import ropuf_pkg::*;

  localparam int LIM  = 34000;
  localparam int LAT  = 33025;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;
  int   cyc    = 0;
  logic prev_busy;

  bit         mon_on = 1'b0;
  int         clr_cnt, en_cnt, c255, en_bad, cnt_bad;
  logic [7:0] prev_cnt = '0;
  logic       prev_clr = 1'b0;

  always #5 clk = ~clk;

  ropuf_key_collector_if bus();

  ropuf_key_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic cmp_model(int m, int p, int c);
    case (m)
      0: return 1'b1;
      1: return (p % 2) == 0;
      2: case (p)
           0: return c inside {245, 246, 247, 249};
           1: return c inside {245, 247, 249};
           2: return (c < 245) || (c > 250);
           3: return (c >= 245) && (c <= 250);
           4: return (c >= 245) && (c <= 249);
           default: return 1'b0;
         endcase
      default: return 1'b0;
    endcase
  endfunction

  always_comb
    bus.cmp_out = cmp_model(mode, int'(bus.pair_sel), int'(bus.count));

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    prev_busy = bus.busy;
    @(negedge clk);
    cyc++;
  endtask

  // start is sampled on the edge between the two negedges; cyc=0 there
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.ro_clr) clr_cnt++;
      if (bus.ro_en) en_cnt++;
      if (bus.ro_en && bus.count >= 8'd245) en_bad++;
      if (bus.ro_en && bus.ro_clr) en_bad++;
      if (bus.count == 8'd255) c255++;
      if (bus.count != 8'd0 && bus.count != prev_cnt + 8'd1) cnt_bad++;
      if (bus.ro_clr && prev_clr) cnt_bad++;
      prev_cnt = bus.count;
      prev_clr = bus.ro_clr;
    end
  end

  initial begin
    logic [127:0] all1;
    logic [127:0] alt;
    all1 = '1;
    alt  = {8{16'hAAAA}};
    rst  = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", 128'(bus.count), 128'd0);
    chk("rst_ctl", 128'({bus.ro_en, bus.ro_clr, bus.busy, bus.key_valid}), 128'd0);
    chk("rst_key", bus.key, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // pattern run, interrupted by reset in pair 5
    mode = 2;
    pulse_start();
    chk("busy_after_start", 128'(bus.busy), 128'd1);
    chk("clr_after_start", 128'(bus.ro_clr), 128'd1);
    while (bus.pair_sel != 7'd5 && cyc < LIM) step();
    chk("vote_patterns", bus.key, 128'h13);
    while (bus.count != 8'd100 && cyc < LIM) step();
    chk("ro_en_mid", 128'({bus.ro_en, bus.busy}), 128'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", 128'({bus.count, bus.ro_en, bus.ro_clr, bus.pair_sel,
                            bus.busy, bus.key_valid}), 128'd0);
    chk("midrst_key", bus.key, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // all-ones run with an ignored start at pair 40
    mode = 0;
    clr_cnt = 0; en_cnt = 0; c255 = 0; en_bad = 0; cnt_bad = 0;
    prev_cnt = '0; prev_clr = 1'b0;
    mon_on = 1'b1;
    pulse_start();
    while (bus.pair_sel != 7'd40 && cyc < LIM) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("start_ignored", 128'({bus.pair_sel, bus.busy}), 128'({7'd40, 1'b1}));
    while (!bus.key_valid && cyc < LIM) step();
    mon_on = 1'b0;
    // cyc+1 = edge on which key_valid is first sampled high
    chk("latency_ones", 128'(cyc + 1), 128'(LAT));
    chk("busy_fall", 128'({prev_busy, bus.busy}), 128'b10);
    chk("key_ones", bus.key, all1);
    chk("clr_pulses", 128'(clr_cnt), 128'd128);
    chk("ro_en_cycles", 128'(en_cnt), 128'(128 * 245));
    chk("count_top", 128'(c255), 128'd128);
    chk("ro_en_bad", 128'(en_bad), 128'd0);
    chk("count_seq", 128'(cnt_bad), 128'd0);
    repeat (3) @(negedge clk);
    chk("done_hold", 128'({bus.key_valid, bus.busy, bus.pair_sel}),
        128'({1'b1, 1'b0, 7'd127}));

    // restart from DONE with even-pair pattern
    mode = 1;
    pulse_start();
    chk("restart_kv", 128'({bus.key_valid, bus.busy, bus.pair_sel}),
        128'({1'b0, 1'b1, 7'd0}));
    chk("restart_key", bus.key, 128'd0);
    while (!bus.key_valid && cyc < LIM) step();
    chk("latency_alt", 128'(cyc + 1), 128'(LAT));
    chk("key_alt", bus.key, alt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
